// File: rtl/st7735_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one st7735 pixel stream between two sources.
// Optional owner lock (lock0/lock1 ports) is enabled by defining ST7735_ARB_LOCK_EN.
module st7735_frame_arbiter #(
    parameter int                      C_x_size     = 128,
    parameter int                      C_y_size     = 160,
    parameter int                      C_color_bits = 16,
    parameter logic [C_color_bits-1:0] C_bg_color   = 16'h0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    next_pixel,
    output logic [6:0]              x,
    output logic [7:0]              y,
    output logic [C_color_bits-1:0] color,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [C_color_bits-1:0] color0,
    input  logic [C_color_bits-1:0] color1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    frame_done,
    output logic [7:0]              frame_count
`ifdef ST7735_ARB_LOCK_EN
    ,
    input  logic                    lock0,
    input  logic                    lock1
`endif
);

    localparam logic [6:0] X_LAST = 7'(C_x_size - 1);
    localparam logic [7:0] Y_LAST = 8'(C_y_size - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state_q, state_d;
    logic   last_served_q, last_served_d;
    logic   boundary, sof_arb;
    logic   hold0, hold1;

    assign boundary = next_pixel && (x == X_LAST) && (y == Y_LAST);
    // An idle arbiter parked at (0,0) may grant before the first pixel is consumed.
    assign sof_arb  = (state_q == IDLE) && (x == 7'd0) && (y == 8'd0) && !next_pixel;

`ifdef ST7735_ARB_LOCK_EN
    assign hold0 = lock0 && req0;
    assign hold1 = lock1 && req1;
`else
    assign hold0 = 1'b0;
    assign hold1 = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        if (boundary || sof_arb) begin
            case (state_q)
                OWN0: begin
                    if (hold0)      state_d = OWN0;
                    else if (req1)  state_d = OWN1;
                    else if (req0)  state_d = OWN0;
                    else            state_d = IDLE;
                end
                OWN1: begin
                    if (hold1)      state_d = OWN1;
                    else if (req0)  state_d = OWN0;
                    else if (req1)  state_d = OWN1;
                    else            state_d = IDLE;
                end
                default: begin
                    if (req0 && req1) state_d = last_served_q ? OWN0 : OWN1;
                    else if (req0)    state_d = OWN0;
                    else if (req1)    state_d = OWN1;
                    else              state_d = IDLE;
                end
            endcase
        end
        if (state_d == OWN0)      last_served_d = 1'b0;
        else if (state_d == OWN1) last_served_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
        end
    end

    // Scan position and frame bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= 7'd0;
            y           <= 8'd0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            frame_done <= boundary;
            if (boundary) frame_count <= frame_count + 8'd1;
            if (next_pixel) begin
                if (x == X_LAST) begin
                    x <= 7'd0;
                    y <= (y == Y_LAST) ? 8'd0 : y + 8'd1;
                end else begin
                    x <= x + 7'd1;
                end
            end
        end
    end

    assign gnt0 = (state_q == OWN0);
    assign gnt1 = (state_q == OWN1);

    always_comb begin
        case (state_q)
            OWN0:    color = color0;
            OWN1:    color = color1;
            default: color = C_bg_color;
        endcase
    end

endmodule

// File: tb/tb_st7735_frame_arbiter.sv
// Bench for st7735_frame_arbiter on a reduced 12x10 frame; reference model tracks a pixel index and an owner.
module tb_st7735_frame_arbiter;
    localparam int          XS = 12;
    localparam int          YS = 10;
    localparam int          N  = XS * YS;
    localparam logic [15:0] BG = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst, next_pixel, req0, req1;
    logic [15:0] color0, color1, color;
    logic [6:0]  x;
    logic [7:0]  y;
    logic        gnt0, gnt1, frame_done;
    logic [7:0]  frame_count;
`ifdef ST7735_ARB_LOCK_EN
    logic        lock0, lock1;
`endif

    always #5 clk = ~clk;

    st7735_frame_arbiter #(
        .C_x_size(XS), .C_y_size(YS), .C_color_bits(16), .C_bg_color(BG)
    ) dut (
        .clk(clk), .rst(rst), .next_pixel(next_pixel), .x(x), .y(y), .color(color),
        .req0(req0), .req1(req1), .color0(color0), .color1(color1),
        .gnt0(gnt0), .gnt1(gnt1), .frame_done(frame_done), .frame_count(frame_count)
`ifdef ST7735_ARB_LOCK_EN
        , .lock0(lock0), .lock1(lock1)
`endif
    );

    int checks = 0;
    int errors = 0;
    int done_seen;
    // Reference model: pixel index in frame, owner (-1 none), last served, frame count.
    int m_p, m_own, m_last, m_fc;
    logic m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p = 0; m_own = -1; m_last = 1; m_fc = 0; m_done = 1'b0;
    endtask

    task automatic model_step(input logic np, input logic r0, input logic r1);
        logic bnd, sof, keep, rself, rother;
        int nxt;
        bnd    = np && (m_p == N - 1);
        sof    = (m_own < 0) && (m_p == 0) && !np;
        m_done = bnd;
        if (np) m_p = (m_p + 1) % N;
        if (bnd) m_fc = (m_fc + 1) % 256;
        if (bnd || sof) begin
            nxt  = m_own;
            keep = 1'b0;
`ifdef ST7735_ARB_LOCK_EN
            keep = (m_own == 0 && lock0 && r0) || (m_own == 1 && lock1 && r1);
`endif
            if (!keep) begin
                if (m_own >= 0) begin
                    rself  = (m_own == 0) ? r0 : r1;
                    rother = (m_own == 0) ? r1 : r0;
                    if (rother)     nxt = 1 - m_own;
                    else if (rself) nxt = m_own;
                    else            nxt = -1;
                end else if (r0 && r1) nxt = 1 - m_last;
                else if (r0)           nxt = 0;
                else if (r1)           nxt = 1;
                else                   nxt = -1;
            end
            m_own = nxt;
            if (nxt >= 0) m_last = nxt;
        end
    endtask

    task automatic check_all();
        logic [15:0] ec;
        ec = (m_own == 0) ? color0 : (m_own == 1) ? color1 : BG;
        chk("x", 32'(x), 32'(m_p % XS));
        chk("y", 32'(y), 32'(m_p / XS));
        chk("gnt0", 32'(gnt0), 32'(m_own == 0));
        chk("gnt1", 32'(gnt1), 32'(m_own == 1));
        chk("color", 32'(color), 32'(ec));
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("frame_count", 32'(frame_count), 32'(m_fc));
    endtask

    task automatic step(input logic np, input logic r0, input logic r1);
        next_pixel = np; req0 = r0; req1 = r1;
        color0 = 16'($urandom); color1 = 16'($urandom);
        model_step(np, r0, r1);
        @(posedge clk); #1;
        if (frame_done) done_seen++;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        rst = 1'b0;
        done_seen = 0;
    endtask

    initial begin
        rst = 1'b0; next_pixel = 1'b0; req0 = 1'b0; req1 = 1'b0;
        color0 = 16'h0; color1 = 16'h0; done_seen = 0;
`ifdef ST7735_ARB_LOCK_EN
        lock0 = 1'b0; lock1 = 1'b0;
`endif
        #2;
        do_reset();

        // No requests: background for a full frame plus a few pixels.
        repeat (N + 5) step(1'b1, 1'b0, 1'b0);
        chk("idle_done_pulses", 32'(done_seen), 32'd1);
        chk("idle_frame_count", 32'(frame_count), 32'd1);

        // req0 from reset: grant before (0,0) is consumed, owns three frames.
        do_reset();
        step(1'b0, 1'b1, 1'b0);
        chk("sof_gnt0", 32'(gnt0), 32'd1);
        repeat (3 * N) step(1'b1, 1'b1, 1'b0);
        chk("own0_frame_count", 32'(frame_count), 32'd3);

        // Both requesting: alternate per frame, random pixel pacing.
        do_reset();
        repeat (3 * N + 40) step(1'($urandom_range(0, 3) != 0), 1'b1, 1'b1);

        // req1 arrives mid-frame while idle: waits for the boundary.
        do_reset();
        repeat (4 * XS + 5) step(1'b1, 1'b0, 1'b0);
        repeat (N) step(1'b1, 1'b0, 1'b1);
        chk("late_req_gnt1", 32'(gnt1), 32'd1);

        // Reset mid-frame while owned by source 1.
        do_reset();
        step(1'b0, 1'b0, 1'b1);
        repeat (N / 2 + 6) step(1'b1, 1'b0, 1'b1);
        do_reset();
        step(1'b1, 1'b0, 1'b0);

        // Random requests and pacing, including dropped requests mid-frame.
        do_reset();
        repeat (700) begin
`ifdef ST7735_ARB_LOCK_EN
            lock0 = 1'($urandom_range(0, 1));
            lock1 = 1'($urandom_range(0, 1));
`endif
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef ST7735_ARB_LOCK_EN
        // Owner 0 locks for three frames, then releases to source 1.
        lock0 = 1'b0; lock1 = 1'b0;
        do_reset();
        lock0 = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        repeat (3 * N) step(1'b1, 1'b1, 1'b1);
        chk("lock_kept_gnt0", 32'(gnt0), 32'd1);
        lock0 = 1'b0;
        repeat (N) step(1'b1, 1'b1, 1'b1);
        chk("lock_release_gnt1", 32'(gnt1), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
